// File: rtl/tri_feeder.sv
// Transmit side of the rasterizer triangle interface: walks a per-frame triangle
// list in synchronous memory and hands each triangle over with valid/ready.
module tri_feeder #(
   parameter int unsigned NUM_TRI     = 12,
   parameter int unsigned COORD_W     = 9,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 frame_start_in,
   output logic [ADDR_W-1:0]    mem_addr_out,
   input  logic [9*COORD_W-1:0] mem_data_in,
   input  logic                 tri_ready_in,
   output logic [9*COORD_W-1:0] triangle_out,
   output logic                 valid_tri_out,
   output logic                 new_frame_out,
   output logic                 obj_done_out,
   output logic                 busy_out
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((NUM_TRI == 0) ? 0 : NUM_TRI - 1);
   localparam logic [2:0]        LAT      = 3'(MEM_LATENCY);

   typedef enum logic [2:0] {
      IDLE,
      NEWFRAME,
      FETCH,
      SEND,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              pending;
   logic [2:0]        lat_cnt;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= IDLE;
         idx           <= '0;
         pending       <= 1'b0;
         lat_cnt       <= '0;
         mem_addr_out  <= '0;
         triangle_out  <= '0;
         valid_tri_out <= 1'b0;
         new_frame_out <= 1'b0;
         obj_done_out  <= 1'b0;
         busy_out      <= 1'b0;
      end else begin
         new_frame_out <= 1'b0;
         obj_done_out  <= 1'b0;

         // Requests arriving during a pass collapse into a single follow-up pass.
         if (frame_start_in && (state != IDLE))
            pending <= 1'b1;

         case (state)
            IDLE: begin
               if (frame_start_in || pending) begin
                  pending       <= 1'b0;
                  state         <= NEWFRAME;
                  new_frame_out <= 1'b1;
                  busy_out      <= 1'b1;
               end
            end

            NEWFRAME: begin
               idx <= '0;
               if (NUM_TRI == 0) begin
                  state        <= DONE;
                  obj_done_out <= 1'b1;
               end else begin
                  state        <= FETCH;
                  mem_addr_out <= '0;
                  lat_cnt      <= '0;
               end
            end

            // The first fetch of a frame waits one extra cycle for the address
            // issued on entry; later fetches start counting at 1.
            FETCH: begin
               if (lat_cnt == LAT) begin
                  triangle_out  <= mem_data_in;
                  valid_tri_out <= 1'b1;
                  state         <= SEND;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end

            SEND: begin
               if (tri_ready_in) begin
                  valid_tri_out <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state        <= DONE;
                     obj_done_out <= 1'b1;
                  end else begin
                     idx          <= idx + 1'b1;
                     mem_addr_out <= idx + 1'b1;
                     lat_cnt      <= 3'd1;
                     state        <= FETCH;
                  end
               end
            end

            DONE: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end

            default: begin
               state         <= IDLE;
               valid_tri_out <= 1'b0;
               busy_out      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_feeder.sv
// Directed bench for tri_feeder: timing of a 3-triangle frame, backpressure,
// request collapsing, empty frame and coordinate packing.
module tb_tri_feeder;

   localparam int unsigned CW = 9;
   localparam int unsigned AW = 8;

   logic           clk;
   logic           rst;
   logic           fs;
   logic           fs0;
   logic           ready;
   logic           ready0;
   logic           pack_mode;

   logic [AW-1:0]   mem_addr;
   logic [9*CW-1:0] mem_q;
   logic [9*CW-1:0] tri_o;
   logic            valid;
   logic            nf;
   logic            od;
   logic            busy;

   logic [AW-1:0]   mem_addr0;
   logic [9*CW-1:0] zero_word;
   logic [9*CW-1:0] tri_o0;
   logic            valid0;
   logic            nf0;
   logic            od0;
   logic            busy0;

   int errors = 0;
   int checks = 0;

   tri_feeder #(.NUM_TRI(3), .COORD_W(CW), .ADDR_W(AW), .MEM_LATENCY(2)) dut (
      .clk_in(clk), .rst_in(rst), .frame_start_in(fs),
      .mem_addr_out(mem_addr), .mem_data_in(mem_q), .tri_ready_in(ready),
      .triangle_out(tri_o), .valid_tri_out(valid), .new_frame_out(nf),
      .obj_done_out(od), .busy_out(busy)
   );

   tri_feeder #(.NUM_TRI(0), .COORD_W(CW), .ADDR_W(AW), .MEM_LATENCY(2)) dut0 (
      .clk_in(clk), .rst_in(rst), .frame_start_in(fs0),
      .mem_addr_out(mem_addr0), .mem_data_in(zero_word), .tri_ready_in(ready0),
      .triangle_out(tri_o0), .valid_tri_out(valid0), .new_frame_out(nf0),
      .obj_done_out(od0), .busy_out(busy0)
   );

   function automatic logic [9*CW-1:0] word_of(input logic [AW-1:0] a, input logic pk);
      logic [9*CW-1:0] w;
      w = '0;
      for (int c = 0; c < 9; c++)
         w[c*CW +: CW] = 9'(a) + 9'd1;
      if (pk)
         w[8*CW +: CW] = 9'h1A5;
      return w;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Two-cycle memory: address register inside the DUT plus this data register.
   always @(posedge clk)
      mem_q <= word_of(mem_addr, pack_mode);

   task automatic do_reset();
      rst = 1'b1;
      fs = 1'b0;
      fs0 = 1'b0;
      ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise the request for edge 0; returns at the cycle-1 sample point.
   task automatic start_frame(input logic which0);
      @(negedge clk);
      if (which0) fs0 = 1'b1; else fs = 1'b1;
      @(posedge clk);
      #1;
      fs = 1'b0;
      fs0 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({valid, nf, od, busy, mem_addr, tri_o} !== '0) begin
         errors++;
         $display("FAIL reset_idle: outputs=%h required 0", {valid, nf, od, busy, mem_addr, tri_o});
      end
      ready = 1'b0;
      start_frame(1'b0);
      for (int c = 2; c <= 6; c++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (valid !== 1'b1 || tri_o !== word_of(8'd0, 1'b0)) begin
         errors++;
         $display("FAIL reset_pre_send: valid=%b tri=%h required valid=1 tri=%h", valid, tri_o, word_of(8'd0, 1'b0));
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({valid, nf, od, busy, mem_addr, tri_o} !== '0) begin
         errors++;
         $display("FAIL reset_async: outputs=%h required 0", {valid, nf, od, busy, mem_addr, tri_o});
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ready = 1'b1;
      for (int c = 0; c < 3; c++) @(posedge clk);
      #1;
      checks++;
      if ({valid, nf, od, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: valid/nf/od/busy=%b required 0000", {valid, nf, od, busy});
      end
   endtask

   task automatic test_basic();
      logic ev;
      do_reset();
      start_frame(1'b0);
      for (int c = 1; c <= 16; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         checks++;
         if (nf !== (c == 1)) begin
            errors++;
            $display("FAIL basic_new_frame c=%0d: got %b required %b", c, nf, (c == 1));
         end
         ev = (c == 5 || c == 8 || c == 11);
         checks++;
         if (valid !== ev) begin
            errors++;
            $display("FAIL basic_valid c=%0d: got %b required %b", c, valid, ev);
         end
         if (ev) begin
            checks++;
            if (tri_o !== word_of(8'((c - 5) / 3), 1'b0)) begin
               errors++;
               $display("FAIL basic_tri c=%0d: got %h required %h", c, tri_o, word_of(8'((c - 5) / 3), 1'b0));
            end
         end
         checks++;
         if (od !== (c == 12)) begin
            errors++;
            $display("FAIL basic_obj_done c=%0d: got %b required %b", c, od, (c == 12));
         end
         checks++;
         if (busy !== (c <= 12)) begin
            errors++;
            $display("FAIL basic_busy c=%0d: got %b required %b", c, busy, (c <= 12));
         end
         if (c == 2 || c == 6 || c == 9 || c == 16) begin
            checks++;
            if (mem_addr !== ((c == 2) ? 8'd0 : (c == 6) ? 8'd1 : 8'd2)) begin
               errors++;
               $display("FAIL basic_addr c=%0d: got %0d required %0d", c, mem_addr,
                        ((c == 2) ? 0 : (c == 6) ? 1 : 2));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic ev;
      do_reset();
      start_frame(1'b0);
      for (int c = 1; c <= 24; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         ready = !(c >= 8 && c <= 17);
         ev = (c == 5) || (c >= 8 && c <= 18) || (c == 21);
         checks++;
         if (valid !== ev) begin
            errors++;
            $display("FAIL bp_valid c=%0d: got %b required %b", c, valid, ev);
         end
         if (c >= 8 && c <= 18) begin
            checks++;
            if (tri_o !== word_of(8'd1, 1'b0)) begin
               errors++;
               $display("FAIL bp_stable c=%0d: got %h required %h", c, tri_o, word_of(8'd1, 1'b0));
            end
         end
         checks++;
         if (od !== (c == 22)) begin
            errors++;
            $display("FAIL bp_obj_done c=%0d: got %b required %b", c, od, (c == 22));
         end
      end
      ready = 1'b1;
   endtask

   task automatic test_pending();
      logic ev;
      int nf_count;
      nf_count = 0;
      do_reset();
      start_frame(1'b0);
      for (int c = 1; c <= 30; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         fs = (c == 3 || c == 5 || c == 7);
         if (nf) nf_count++;
         checks++;
         if (nf !== (c == 1 || c == 14)) begin
            errors++;
            $display("FAIL pend_new_frame c=%0d: got %b required %b", c, nf, (c == 1 || c == 14));
         end
         checks++;
         if (od !== (c == 12 || c == 25)) begin
            errors++;
            $display("FAIL pend_obj_done c=%0d: got %b required %b", c, od, (c == 12 || c == 25));
         end
         ev = (c == 5 || c == 8 || c == 11 || c == 18 || c == 21 || c == 24);
         checks++;
         if (valid !== ev) begin
            errors++;
            $display("FAIL pend_valid c=%0d: got %b required %b", c, valid, ev);
         end
      end
      fs = 1'b0;
      checks++;
      if (nf_count != 2) begin
         errors++;
         $display("FAIL pend_pass_count: got %0d new_frame pulses required 2", nf_count);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pend_final_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_empty();
      do_reset();
      start_frame(1'b1);
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         checks++;
         if ({nf0, od0, valid0, busy0} !== {(c == 1), (c == 2), 1'b0, (c <= 2)}) begin
            errors++;
            $display("FAIL empty c=%0d: nf/od/valid/busy=%b required %b", c, {nf0, od0, valid0, busy0},
                     {(c == 1), (c == 2), 1'b0, (c <= 2)});
         end
         checks++;
         if (mem_addr0 !== 8'd0 || tri_o0 !== '0) begin
            errors++;
            $display("FAIL empty_data c=%0d: addr=%0d tri=%h required 0", c, mem_addr0, tri_o0);
         end
      end
   endtask

   task automatic test_packing();
      logic [CW-1:0] v2z;
      logic [CW-1:0] v2y;
      logic [CW-1:0] v0x;
      do_reset();
      pack_mode = 1'b1;
      start_frame(1'b0);
      for (int c = 2; c <= 5; c++) begin
         @(posedge clk);
         #1;
      end
      v2z = tri_o[8*CW +: CW];
      v2y = tri_o[7*CW +: CW];
      v0x = tri_o[0 +: CW];
      checks++;
      if (valid !== 1'b1 || v2z !== 9'h1A5) begin
         errors++;
         $display("FAIL pack_v2z: valid=%b v2z=%h required valid=1 v2z=1a5", valid, v2z);
      end
      checks++;
      if (v2y !== 9'd1 || v0x !== 9'd1) begin
         errors++;
         $display("FAIL pack_others: v2y=%h v0x=%h required 001 001", v2y, v0x);
      end
      for (int c = 6; c <= 13; c++) @(posedge clk);
      pack_mode = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      fs = 1'b0;
      fs0 = 1'b0;
      ready = 1'b1;
      ready0 = 1'b1;
      pack_mode = 1'b0;
      zero_word = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_pending();
      test_empty();
      test_packing();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
